// File: rtl/adder_sched_pkg.sv
// Shared types and helpers for the adder_scheduler block.
//   sched_state_e : scheduler FSM states
//   rr_next       : round-robin pointer increment with wrap at n
package adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESPOND = 2'd2
  } sched_state_e;

  // Next round-robin pointer after serving index ptr, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return ((ptr + 32'd1) >= n) ? 32'd0 : (ptr + 32'd1);
  endfunction

endpackage

// File: rtl/adder.sv
// Shared combinational adder datapath.
//   a_i, b_i : operands (N_BITS)
//   sum_o    : sum mod 2**N_BITS
//   carry_o  : carry-out of the addition
module adder #(
  parameter int unsigned N_BITS = 8
) (
  input  logic [N_BITS-1:0] a_i,
  input  logic [N_BITS-1:0] b_i,
  output logic [N_BITS-1:0] sum_o,
  output logic              carry_o
);

  localparam int unsigned SUM_W = N_BITS + 1;

  // Add at one extra bit so the carry falls out as the MSB.
  assign {carry_o, sum_o} = SUM_W'(a_i) + SUM_W'(b_i);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i     : request vector (N_REQ)
//   ptr_i     : highest-priority index for this decision
//   grant_o_c : one-hot grant, zero when no request
//   idx_o_c   : encoded index of the granted request
//   any_o_c   : at least one request present
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o_c,
  output logic [ID_W-1:0]  idx_o_c,
  output logic             any_o_c
);

  int unsigned     pos;
  logic [ID_W-1:0] cand;
  logic            found;

  // Scan ptr, ptr+1, ... (mod N_REQ) and take the first asserted request.
  always_comb begin
    grant_o_c = '0;
    idx_o_c   = '0;
    found     = 1'b0;
    pos       = 32'd0;
    cand      = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      pos = 32'(ptr_i) + off;
      if (pos >= N_REQ) begin
        pos = pos - N_REQ;
      end
      cand = ID_W'(pos);
      if (!found && req_i[cand]) begin
        found           = 1'b1;
        grant_o_c[cand] = 1'b1;
        idx_o_c         = cand;
      end
    end
    any_o_c = found;
  end

endmodule

// File: rtl/adder_scheduler.sv
// Shares one adder between N_REQ requesters with round-robin arbitration.
// One operation in flight: IDLE (grant) -> COMPUTE (register sum) -> RESPOND
// (hold until accepted). Build option ADDER_SCHED_SATURATE_EN clamps the
// result to all-ones on overflow; overflow is still reported.
//   i_clk, i_rst_n     : clock, async active-low reset
//   i_req_valid        : per-requester request valid
//   o_req_ready        : per-requester accept, one-hot or zero, IDLE only
//   i_req_operand1/2   : packed per-requester operands
//   o_rsp_valid        : response valid, i_rsp_ready : response accept
//   o_rsp_id           : served requester index
//   o_rsp_result       : sum (wrapped, or saturated in the macro build)
//   o_rsp_overflow     : carry-out of the addition
//   o_busy             : scheduler not in IDLE
module adder_scheduler
  import adder_sched_pkg::*;
#(
  parameter int unsigned N_BITS = 8,
  parameter int unsigned N_REQ  = 4,
  localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [N_REQ-1:0]               i_req_valid,
  output logic [N_REQ-1:0]               o_req_ready,
  input  logic [N_REQ-1:0][N_BITS-1:0]   i_req_operand1,
  input  logic [N_REQ-1:0][N_BITS-1:0]   i_req_operand2,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [ID_W-1:0]                o_rsp_id,
  output logic [N_BITS-1:0]              o_rsp_result,
  output logic                           o_rsp_overflow,
  output logic                           o_busy
);

  sched_state_e      state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [N_BITS-1:0] op1_q, op1_d;
  logic [N_BITS-1:0] op2_q, op2_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [N_BITS-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_overflow_q, rsp_overflow_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              busy_q, busy_d;

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_any;
  logic [N_BITS-1:0] add_sum;
  logic              add_carry;
  logic [N_BITS-1:0] result_c;

  // Arbitration over the live request vector, priority from rr_ptr_q.
  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i     (i_req_valid),
    .ptr_i     (rr_ptr_q),
    .grant_o_c (grant),
    .idx_o_c   (grant_idx),
    .any_o_c   (grant_any)
  );

  // Single shared adder, always fed from the latched operands.
  adder #(
    .N_BITS (N_BITS)
  ) u_adder (
    .a_i     (op1_q),
    .b_i     (op2_q),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  // Result shaping applied before the response register.
`ifdef ADDER_SCHED_SATURATE_EN
  assign result_c = add_carry ? {N_BITS{1'b1}} : add_sum;
`else
  assign result_c = add_sum;
`endif

  // Next-state and datapath-capture logic.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    id_d           = id_q;
    op1_d          = op1_q;
    op2_d          = op2_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    o_req_ready    = '0;

    case (state_q)
      IDLE: begin
        if (grant_any) begin
          o_req_ready = grant;
          op1_d       = i_req_operand1[grant_idx];
          op2_d       = i_req_operand2[grant_idx];
          id_d        = grant_idx;
          rr_ptr_d    = ID_W'(rr_next(32'(grant_idx), N_REQ));
          state_d     = COMPUTE;
        end
      end
      COMPUTE: begin
        rsp_result_d   = result_c;
        rsp_overflow_d = add_carry;
        rsp_id_d       = id_q;
        state_d        = RESPOND;
      end
      RESPOND: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered copies of the next state.
    busy_d      = (state_d != IDLE);
    rsp_valid_d = (state_d == RESPOND);
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      id_q           <= '0;
      op1_q          <= '0;
      op2_q          <= '0;
      rsp_id_q       <= '0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      id_q           <= id_d;
      op1_q          <= op1_d;
      op2_q          <= op2_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_valid_q    <= rsp_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign o_rsp_valid    = rsp_valid_q;
  assign o_rsp_id       = rsp_id_q;
  assign o_rsp_result   = rsp_result_q;
  assign o_rsp_overflow = rsp_overflow_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_adder_scheduler.sv
// Self-checking bench for adder_scheduler (N_BITS=8, N_REQ=4).
module tb_adder_scheduler;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [3:0]      valid;
  logic [3:0][7:0] op1, op2;
  logic            rsp_ready;
  logic [3:0]      o_req_ready;
  logic            o_rsp_valid;
  logic [1:0]      o_rsp_id;
  logic [7:0]      o_rsp_result;
  logic            o_rsp_overflow;
  logic            o_busy;

  always #5 clk = ~clk;

  adder_scheduler #(.N_BITS(8), .N_REQ(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req_valid    (valid),
    .o_req_ready    (o_req_ready),
    .i_req_operand1 (op1),
    .i_req_operand2 (op2),
    .o_rsp_valid    (o_rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_id       (o_rsp_id),
    .o_rsp_result   (o_rsp_result),
    .o_rsp_overflow (o_rsp_overflow),
    .o_busy         (o_busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: -1 idle, 0 adding, 1 response offered
  int phase_m = -1;
  int ptr_m   = 0;
  int pid_m   = 0;
  int pa_m    = 0;
  int pb_m    = 0;
  int nresp_m = 0;
  int mdl_ids[$];
  int dut_ids[$];
  int dut_cyc[$];

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic int exp_result(input int a, input int b);
    int s;
    s = a + b;
`ifdef ADDER_SCHED_SATURATE_EN
    if (s >= 256) return 255;
`endif
    return s % 256;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_m = -1;
      ptr_m   = 0;
    end else if (phase_m < 0) begin
      int g;
      g = pick(valid, ptr_m);
      if (g >= 0) begin
        pid_m   = g;
        pa_m    = int'(op1[g]);
        pb_m    = int'(op2[g]);
        ptr_m   = (g + 1) % N;
        phase_m = 0;
        mdl_ids.push_back(g);
      end
    end else if (phase_m == 0) begin
      phase_m = 1;
    end else if (rsp_ready) begin
      phase_m = -1;
      nresp_m++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int g;
    logic [31:0] exp_rdy;
    cyc++;
    g = pick(valid, ptr_m);
    exp_rdy = (phase_m < 0 && g >= 0) ? (32'd1 << g) : 32'd0;
    chk("req_ready", 32'(o_req_ready), exp_rdy);
    chk("busy", 32'(o_busy), 32'(phase_m >= 0));
    chk("rsp_valid", 32'(o_rsp_valid), 32'(phase_m == 1));
    if (phase_m == 1) begin
      chk("rsp_id", 32'(o_rsp_id), 32'(pid_m));
      chk("rsp_result", 32'(o_rsp_result), 32'(exp_result(pa_m, pb_m)));
      chk("rsp_overflow", 32'(o_rsp_overflow), 32'(pa_m + pb_m >= 256));
    end else if (!rst_n) begin
      chk("rst_id", 32'(o_rsp_id), 32'd0);
      chk("rst_result", 32'(o_rsp_result), 32'd0);
      chk("rst_overflow", 32'(o_rsp_overflow), 32'd0);
    end
    if (o_rsp_valid && rsp_ready) begin
      dut_ids.push_back(int'(o_rsp_id));
      dut_cyc.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rnd_op();
    return ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
  endfunction

  task automatic drain();
    valid     = '0;
    rsp_ready = 1'b1;
    repeat (4) step();
  endtask

  task automatic auto_cycle(input bit all_valid, input bit rand_ready);
    logic [3:0] seen;
    @(negedge clk);
    seen = o_req_ready;
    step();
    for (int i = 0; i < N; i++) begin
      if (seen[i]) begin
        op1[i]   = rnd_op();
        op2[i]   = rnd_op();
        valid[i] = all_valid ? 1'b1 : ($urandom_range(0, 3) != 0);
      end else if (!all_valid) begin
        if (valid[i]) begin
          if ($urandom_range(0, 7) == 0) valid[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          op1[i]   = rnd_op();
          op2[i]   = rnd_op();
          valid[i] = 1'b1;
        end
      end
    end
    rsp_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seen;
    int ids_exp[5];
    int fair_exp[3];
    int guard;
    valid = '0; op1 = '0; op2 = '0; rsp_ready = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(o_req_ready), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single request: FF + 01
    step();
    valid = 4'b0001; op1[0] = 8'hFF; op2[0] = 8'h01;
    @(negedge clk); chk("single_ready", 32'(o_req_ready), 32'h1);
    step(); valid = '0;
    @(negedge clk); chk("single_wait", 32'(o_rsp_valid), 32'd0);
    step();
    @(negedge clk);
    chk("single_valid", 32'(o_rsp_valid), 32'd1);
    chk("single_id", 32'(o_rsp_id), 32'd0);
`ifdef ADDER_SCHED_SATURATE_EN
    chk("single_result", 32'(o_rsp_result), 32'hFF);
`else
    chk("single_result", 32'(o_rsp_result), 32'h00);
`endif
    chk("single_overflow", 32'(o_rsp_overflow), 32'd1);
    drain();

    // Round robin from a fresh pointer
    rst_n = 1'b0; step(); rst_n = 1'b1;
    mdl_ids.delete(); dut_ids.delete(); dut_cyc.delete();
    for (int i = 0; i < N; i++) begin op1[i] = rnd_op(); op2[i] = rnd_op(); end
    valid = 4'b1111;
    repeat (16) auto_cycle(1'b1, 1'b0);
    drain();
    ids_exp = '{0, 1, 2, 3, 0};
    chk("rr_count", 32'(dut_ids.size() >= 5), 32'd1);
    if (dut_ids.size() >= 5 && mdl_ids.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("rr_dut_id", 32'(dut_ids[k]), 32'(ids_exp[k]));
        chk("rr_model_id", 32'(mdl_ids[k]), 32'(ids_exp[k]));
      end
      for (int k = 1; k < 5; k++) chk("rr_spacing", 32'(dut_cyc[k] - dut_cyc[k-1]), 32'd3);
    end

    // Backpressure: hold the response for 5 cycles
    rsp_ready = 1'b0;
    valid = 4'b0010; op1[1] = 8'h30; op2[1] = 8'h45;
    @(negedge clk); chk("bp_grant", 32'(o_req_ready), 32'h2);
    step(); valid = 4'b0100; op1[2] = 8'h12; op2[2] = 8'h34;
    @(negedge clk); chk("bp_compute_ready", 32'(o_req_ready), 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(o_rsp_valid), 32'd1);
      chk("bp_hold_result", 32'(o_rsp_result), 32'h75);
      chk("bp_hold_id", 32'(o_rsp_id), 32'd1);
      chk("bp_hold_ready", 32'(o_req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk); chk("bp_release_valid", 32'(o_rsp_valid), 32'd1);
    step();
    @(negedge clk); chk("bp_next_grant", 32'(o_req_ready), 32'h4);
    step(); valid = '0;
    drain();

    // Pointer fairness: req2 alone, then req1+req3
    mdl_ids.delete(); dut_ids.delete(); dut_cyc.delete();
    valid = 4'b0100; op1[2] = rnd_op(); op2[2] = rnd_op();
    @(negedge clk); chk("fair_first", 32'(o_req_ready), 32'h4);
    step();
    valid = 4'b1010;
    op1[1] = rnd_op(); op2[1] = rnd_op(); op1[3] = rnd_op(); op2[3] = rnd_op();
    repeat (12) begin
      @(negedge clk); seen = o_req_ready;
      step(); valid = valid & ~seen;
    end
    drain();
    fair_exp = '{2, 3, 1};
    chk("fair_count", 32'(dut_ids.size()), 32'd3);
    if (dut_ids.size() == 3 && mdl_ids.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("fair_dut_id", 32'(dut_ids[k]), 32'(fair_exp[k]));
        chk("fair_model_id", 32'(mdl_ids[k]), 32'(fair_exp[k]));
      end
    end

    // Reset during COMPUTE
    valid = 4'b0001; op1[0] = 8'h01; op2[0] = 8'h02;
    @(negedge clk); chk("mid_first_grant", 32'(o_req_ready), 32'h1);
    step(); valid = '0;
    drain();
    valid = 4'b0010; op1[1] = 8'h10; op2[1] = 8'h20;
    @(negedge clk); chk("mid_second_grant", 32'(o_req_ready), 32'h2);
    step(); valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("mid_rst_result", 32'(o_rsp_result), 32'd0);
    step(); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); chk("mid_no_rsp", 32'(o_rsp_valid), 32'd0);
      step();
    end
    valid = 4'b1111;
    @(negedge clk); chk("mid_post_grant", 32'(o_req_ready), 32'h1);
    step(); valid = '0;
    drain();

    // Random traffic with random backpressure
    nresp_m = 0;
    dut_ids.delete();
    guard = 0;
    while (nresp_m < 500 && guard < 20000) begin
      auto_cycle(1'b0, 1'b1);
      guard++;
    end
    chk("random_done", 32'(nresp_m >= 500), 32'd1);
    drain();
    chk("random_dut_count", 32'(dut_ids.size()), 32'(nresp_m));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
